// File: rtl/sys_bus_pkg.sv
// Shared definitions for system-bus initiators: FSM state encoding and bus widths.
package sys_bus_pkg;

   localparam int DW = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } bus_state_e;

endpackage

// File: rtl/sys_bus_if.sv
// System bus connection: the initiator drives address/data/strobes, the slave returns rdata/err/ack.
interface sys_bus_if #(
   parameter int AW = 32
) ();

   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic          wen;
   logic          ren;
   logic [31:0]   rdata;
   logic          err;
   logic          ack;

   modport m (output addr, wdata, wen, ren, input rdata, err, ack);
   modport s (input addr, wdata, wen, ren, output rdata, err, ack);

endinterface

// File: rtl/sys_bus_initiator.sv
// Single-outstanding bus initiator: accepts a command, strobes the bus once, waits for ack
// or timeout, then holds a response until it is accepted.
module sys_bus_initiator
   import sys_bus_pkg::*;
#(
   parameter int TMO = 1023,
   parameter int AW  = 32
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          cmd_vld_i,
   output logic          cmd_rdy_o,
   input  logic          cmd_wr_i,
   input  logic [AW-1:0] cmd_addr_i,
   input  logic [31:0]   cmd_wdata_i,
   output logic          rsp_vld_o,
   input  logic          rsp_rdy_i,
   output logic [31:0]   rsp_rdata_o,
   output logic          rsp_err_o,
   output logic          rsp_tmo_o,
   sys_bus_if.m          bus
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid and its payload stay stable until that edge.

   localparam int            CW       = $clog2(TMO + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

   bus_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic          tmo_q;

   logic          cmd_xfer;
   logic          cap_ack;
   logic          cap_tmo;
   logic          wen_c;
   logic          ren_c;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cmd_xfer  = 1'b0;
      cap_ack   = 1'b0;
      cap_tmo   = 1'b0;
      wen_c     = 1'b0;
      ren_c     = 1'b0;
      cmd_rdy_o = 1'b0;
      rsp_vld_o = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_rdy_o = 1'b1;
            if (cmd_vld_i) begin
               cmd_xfer = 1'b1;
               state_d  = STROBE;
            end
         end
         STROBE: begin
            wen_c = wr_q;
            ren_c = ~wr_q;
            if (bus.ack) begin
               cap_ack = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // An ack arriving on the last allowed cycle still wins over the timeout.
            if (bus.ack) begin
               cap_ack = 1'b1;
               state_d = RESP;
            end else if (cnt_q == TMO_LAST) begin
               cap_tmo = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            rsp_vld_o = 1'b1;
            if (rsp_rdy_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (cmd_xfer) begin
            wr_q    <= cmd_wr_i;
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
         end
         if (cap_ack) begin
            rdata_q <= wr_q ? 32'h0 : bus.rdata;
            err_q   <= bus.err;
            tmo_q   <= 1'b0;
         end else if (cap_tmo) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            tmo_q   <= 1'b1;
         end
      end
   end

   assign bus.addr    = addr_q;
   assign bus.wdata   = wdata_q;
   assign bus.wen     = wen_c;
   assign bus.ren     = ren_c;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign rsp_tmo_o   = tmo_q;

endmodule

// File: tb/tb_sys_bus_initiator.sv
// Directed bench for sys_bus_initiator: read/write latency, timeout, slave error, backpressure, reset.
module tb_sys_bus_initiator;

   logic        clk;
   logic        rstn;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic        cmd_wr;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_vld;
   logic        rsp_rdy;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_tmo;

   int n_total = 0;
   int n_bad   = 0;
   logic [31:0] exp_q[$];

   sys_bus_if #(.AW(32)) bus_if ();

   sys_bus_initiator #(.TMO(8), .AW(32)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .cmd_vld_i   (cmd_vld),
      .cmd_rdy_o   (cmd_rdy),
      .cmd_wr_i    (cmd_wr),
      .cmd_addr_i  (cmd_addr),
      .cmd_wdata_i (cmd_wdata),
      .rsp_vld_o   (rsp_vld),
      .rsp_rdy_i   (rsp_rdy),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .rsp_tmo_o   (rsp_tmo),
      .bus         (bus_if)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One transaction from command issue to response handshake. Called at a negedge in IDLE.
   // ack_at: cycle (1 = STROBE) in which the slave raises ack, 0 = never.
   task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at, input logic [31:0] s_rdata,
                          input logic s_err, input int bp, input logic late_ack, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err, input logic exp_tmo);
      int lat = 0;
      int wen_n = 0;
      int ren_n = 0;
      int bad_addr = 0;
      int bp_bad = 0;
      exp_q.push_back(exp_rdata);
      check({tag, "_cmd_rdy"}, {63'b0, cmd_rdy}, 64'd1);
      cmd_vld = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         cmd_vld = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
         if (bus_if.wen) wen_n++;
         if (bus_if.ren) ren_n++;
         if (bus_if.addr !== addr || bus_if.wdata !== wdata) bad_addr++;
         if (rsp_vld) begin
            lat = c;
            break;
         end
         bus_if.ack   = (c == ack_at);
         bus_if.rdata = s_rdata;
         bus_if.err   = s_err;
      end
      bus_if.ack = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_wen_pulses"}, wen_n, wr ? 1 : 0);
      check({tag, "_ren_pulses"}, ren_n, wr ? 0 : 1);
      check({tag, "_addr_wdata_stable"}, bad_addr, 0);
      check({tag, "_rdata"}, rsp_rdata, exp_q.pop_front());
      check({tag, "_err"}, {63'b0, rsp_err}, {63'b0, exp_err});
      check({tag, "_tmo"}, {63'b0, rsp_tmo}, {63'b0, exp_tmo});
      for (int b = 0; b < bp; b++) begin
         bus_if.ack   = late_ack;
         bus_if.rdata = 32'h5A5A_5A5A;
         bus_if.err   = 1'b0;
         @(negedge clk);
         if (rsp_vld !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err ||
             rsp_tmo !== exp_tmo) bp_bad++;
         if (cmd_rdy !== 1'b0 || bus_if.wen !== 1'b0 || bus_if.ren !== 1'b0) bp_bad++;
         if (bus_if.addr !== addr) bp_bad++;
      end
      bus_if.ack = 1'b0;
      if (bp > 0) check({tag, "_backpressure_hold"}, bp_bad, 0);
      rsp_rdy = 1'b1;
      @(negedge clk);
      rsp_rdy = 1'b0;
      check({tag, "_rsp_vld_after_hs"}, {63'b0, rsp_vld}, 64'd0);
      check({tag, "_idle_after_hs"}, {63'b0, cmd_rdy}, 64'd1);
   endtask

   initial begin
      int stray;
      rstn = 1'b0; cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_rdy = 1'b0;
      bus_if.ack = 1'b0; bus_if.rdata = '0; bus_if.err = 1'b0;
      #12;
      check("rst_cmd_rdy", {63'b0, cmd_rdy}, 64'd1);
      check("rst_rsp_vld", {63'b0, rsp_vld}, 64'd0);
      check("rst_rsp_rdata", rsp_rdata, 64'd0);
      check("rst_rsp_err", {63'b0, rsp_err}, 64'd0);
      check("rst_rsp_tmo", {63'b0, rsp_tmo}, 64'd0);
      check("rst_wen_ren", {62'b0, bus_if.wen, bus_if.ren}, 64'd0);
      check("rst_addr", bus_if.addr, 64'd0);
      check("rst_wdata", bus_if.wdata, 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // zero-wait read
      run_txn("zw_read", 1'b0, 32'h4010_0010, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 0, 1'b0,
              2, 32'hDEAD_BEEF, 1'b0, 1'b0);
      // write acked in WAIT cycle 3, slave rdata must not leak into the response
      run_txn("ws_write", 1'b1, 32'h4000_0004, 32'h1234_5678, 4, 32'hFFFF_FFFF, 1'b0, 0, 1'b0,
              5, 32'h0, 1'b0, 1'b0);
      // timeout after 8 WAIT cycles; ack during RESP is ignored
      run_txn("timeout", 1'b0, 32'h4000_0100, 32'h0, 0, 32'hAAAA_5555, 1'b0, 2, 1'b1,
              10, 32'h0, 1'b1, 1'b1);
      // late ack in IDLE must not start anything
      bus_if.ack = 1'b1;
      @(negedge clk);
      bus_if.ack = 1'b0;
      check("late_ack_idle_rdy", {63'b0, cmd_rdy}, 64'd1);
      check("late_ack_idle_vld", {63'b0, rsp_vld}, 64'd0);
      // slave error on a read, acked in WAIT cycle 1
      run_txn("slv_err", 1'b0, 32'h4000_0008, 32'h0, 2, 32'h0BAD_F00D, 1'b1, 0, 1'b0,
              3, 32'h0BAD_F00D, 1'b1, 1'b0);
      // response backpressure for 5 cycles
      run_txn("bp_read", 1'b0, 32'h4000_0020, 32'h0, 1, 32'h1357_9BDF, 1'b0, 5, 1'b0,
              2, 32'h1357_9BDF, 1'b0, 1'b0);
      // ack on the last WAIT cycle beats the timeout
      run_txn("ack_at_tmo", 1'b0, 32'h4000_0030, 32'h0, 9, 32'hCAFE_0001, 1'b0, 0, 1'b0,
              10, 32'hCAFE_0001, 1'b0, 1'b0);
      // zero-wait write with slave err
      run_txn("zw_write_err", 1'b1, 32'h4000_0040, 32'h8765_4321, 1, 32'h1111_2222, 1'b1, 0, 1'b0,
              2, 32'h0, 1'b1, 1'b0);

      // reset while in WAIT drops the transaction
      cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h4000_0050; cmd_wdata = 32'h0;
      @(negedge clk);
      cmd_vld = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("mid_rst_cmd_rdy", {63'b0, cmd_rdy}, 64'd1);
      check("mid_rst_rsp_vld", {63'b0, rsp_vld}, 64'd0);
      check("mid_rst_addr", bus_if.addr, 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rsp_vld !== 1'b0 || cmd_rdy !== 1'b1) stray++;
      end
      check("mid_rst_no_rsp", stray, 0);
      run_txn("post_rst_read", 1'b0, 32'h4000_0060, 32'h0, 3, 32'h0F0F_0F0F, 1'b0, 0, 1'b0,
              4, 32'h0F0F_0F0F, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
